fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the LEGv8 pipeline. It sits directly upstream of decode and signext.
- Holds the PC and reads a 32-bit instruction from a local instruction memory.
- Registers instruction, PC and a valid bit into the IF/ID pipeline register.
- Decode and signext consume instr_ID; the downstream branch adder returns PCBranch/PCSrc for redirect.

Parameters:
N, 64, datapath/PC width in bits
IMEM_DEPTH, 64, instruction memory depth in 32-bit words (power of two)
AW, 6, word-address width, equal to log2(IMEM_DEPTH)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  hazard stall: hold PC and IF/ID
flush  in  1  squash IF/ID contents (insert bubble)
PCSrc  in  1  take branch/redirect this cycle
PCBranch  in  N  redirect target address
imem_we  in  1  instruction memory write enable (bench preload)
imem_waddr  in  AW  instruction memory word address for write
imem_wdata  in  32  instruction word to write
pc_IF  out  N  current PC (fetch address)
instr_ID  out  32  IF/ID registered instruction, feeds signext
pc_ID  out  N  IF/ID registered PC of instr_ID
valid_ID  out  1  IF/ID entry holds a real instruction

Behaviour:
- Reset (reset==0), asynchronous and immediate, independent of clk:
  - pc_IF=0, instr_ID=32'h0, pc_ID=0, valid_ID=0.
  - Instruction memory contents are NOT cleared.
  - Release is sampled at the next rising edge; the first fetch is from address 0.
- Fetch:
  - The combinational read is imem[pc_IF[AW+1:2]]; higher PC bits are ignored (aliasing/wrap).
  - pc_IF[1:0] is always 0.
- Next-PC / IF/ID update at each rising edge while reset==1. Priority, highest first:
  1. PCSrc=1:
     - pc_IF <= {PCBranch[N-1:2],2'b00}.
     - IF/ID <= bubble (instr_ID=0, pc_ID=0, valid_ID=0). The wrong-path instruction is discarded.
     - Applies regardless of stall/flush.
  2. stall=1 and flush=1: pc_IF holds; IF/ID <= bubble.
  3. stall=1: pc_IF holds; IF/ID holds all three fields.
  4. flush=1: pc_IF <= pc_IF+4; IF/ID <= bubble.
  5. Otherwise: pc_IF <= pc_IF+4; instr_ID <= fetched word; pc_ID <= pc_IF; valid_ID <= 1.
- Latency: instruction at address A appears on instr_ID one cycle after pc_IF==A when not stalled.
- PC arithmetic:
  - Modulo 2^N; 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0.
  - No exceptions on misaligned or out-of-range targets; PCBranch[1:0] are dropped.
- Instruction memory write:
  - Synchronous on the rising edge when imem_we=1.
  - A fetch from the same address in that cycle returns the old word; the new word is visible from the next cycle.
  - Writes are allowed during reset and stall.
- A bubble (all-zero instruction) must be harmless downstream: signext yields 0 for it, and valid_ID=0 marks it.
- Initial memory contents are undefined until written; the bench preloads them.

Test Plan:
- Sequential fetch:
  - Stimulus: preload word0=32'hF8400020 (LDUR x0,[x1,#0]), word1=32'hF80513AD, word2=32'hB40001E0 (CBZ x0,#0xf); release reset; no stall/flush/PCSrc.
  - Required: cycles 1..3 show instr_ID=F8400020/F80513AD/B40001E0, pc_ID=0/4/8, valid_ID=1; pc_IF=0xC after 3 edges.
- Stall:
  - Stimulus: assert stall for 2 cycles while instr_ID=F80513AD, pc_IF=8.
  - Required: instr_ID, pc_ID=4, pc_IF=8 held for both cycles; on deassert, instr_ID=B40001E0, pc_ID=8.
- Branch redirect:
  - Stimulus: PCSrc=1, PCBranch=0x3C when pc_IF=8.
  - Required: next edge gives pc_IF=0x3C and valid_ID=0, instr_ID=0; the following edge gives instr_ID=imem[15], pc_ID=0x3C.
  - Also: PCBranch=0x3E forces pc_IF=0x3C.
- Priority conflicts:
  - Stimulus: PCSrc=1 with stall=1 → required: redirect taken, bubble.
  - Stimulus: stall=1, flush=1 → required: pc_IF held, valid_ID=0.
  - Stimulus: flush alone → required: pc_IF+4, bubble.
- Async reset mid-run:
  - Stimulus: drop reset between edges at pc_IF=0x10, valid_ID=1.
  - Required: outputs go to 0 immediately without a clk edge; after release, fetch resumes from 0 with the memory contents intact (instr_ID=F8400020).
- Wrap and write timing:
  - Stimulus: PCBranch=64'hFFFF_FFFF_FFFF_FFFC.
  - Required: next pc_IF=0, pc_ID=FFFF_FFFF_FFFF_FFFC, instr_ID=imem[63].
  - Stimulus: write word0=32'h8B020020 while pc_IF=0.
  - Required: old word latched that cycle; new word seen on the next fetch of 0.

Source files
------------

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: PC register, local instruction memory and the
// IF/ID pipeline register feeding decode/signext.
module fetch_stage #(
  parameter int N          = 64,
  parameter int IMEM_DEPTH = 64,
  parameter int AW         = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          PCSrc,
  input  logic [N-1:0]  PCBranch,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_waddr,
  input  logic [31:0]   imem_wdata,
  output logic [N-1:0]  pc_IF,
  output logic [31:0]   instr_ID,
  output logic [N-1:0]  pc_ID,
  output logic          valid_ID
);

  localparam logic [N-1:0] PC_STEP    = N'(4);
  localparam logic [N-1:0] ALIGN_MASK = ~(N'(3));

  typedef enum logic [2:0] {
    UPD_REDIRECT    = 3'd0,
    UPD_STALL_FLUSH = 3'd1,
    UPD_STALL       = 3'd2,
    UPD_FLUSH       = 3'd3,
    UPD_ADVANCE     = 3'd4
  } upd_e;

  logic [31:0]  imem [IMEM_DEPTH];
  logic [31:0]  fetch_word;
  logic [N-1:0] pc_seq;
  upd_e         upd;

  logic [N-1:0] pc_next;
  logic [31:0]  instr_next;
  logic [N-1:0] pc_id_next;
  logic         valid_next;

  // Upper PC bits are ignored, so fetch addresses alias modulo the memory size.
  assign fetch_word = imem[pc_IF[AW+1:2]];
  assign pc_seq     = pc_IF + PC_STEP;

  // Instruction memory write port; deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  // Resolve which update rule applies this cycle, redirect first.
  always_comb begin
    upd = UPD_ADVANCE;
    if (PCSrc) begin
      upd = UPD_REDIRECT;
    end else if (stall && flush) begin
      upd = UPD_STALL_FLUSH;
    end else if (stall) begin
      upd = UPD_STALL;
    end else if (flush) begin
      upd = UPD_FLUSH;
    end else begin
      upd = UPD_ADVANCE;
    end
  end

  // Next PC and next IF/ID contents for the selected rule.
  always_comb begin
    pc_next    = pc_IF;
    instr_next = instr_ID;
    pc_id_next = pc_ID;
    valid_next = valid_ID;
    case (upd)
      UPD_REDIRECT: begin
        pc_next    = PCBranch & ALIGN_MASK;
        instr_next = 32'h0000_0000;
        pc_id_next = '0;
        valid_next = 1'b0;
      end
      UPD_STALL_FLUSH: begin
        pc_next    = pc_IF;
        instr_next = 32'h0000_0000;
        pc_id_next = '0;
        valid_next = 1'b0;
      end
      UPD_STALL: begin
        pc_next    = pc_IF;
        instr_next = instr_ID;
        pc_id_next = pc_ID;
        valid_next = valid_ID;
      end
      UPD_FLUSH: begin
        pc_next    = pc_seq;
        instr_next = 32'h0000_0000;
        pc_id_next = '0;
        valid_next = 1'b0;
      end
      UPD_ADVANCE: begin
        pc_next    = pc_seq;
        instr_next = fetch_word;
        pc_id_next = pc_IF;
        valid_next = 1'b1;
      end
      default: begin
        pc_next    = '0;
        instr_next = 32'h0000_0000;
        pc_id_next = '0;
        valid_next = 1'b0;
      end
    endcase
  end

  // PC and IF/ID pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_IF    <= '0;
      instr_ID <= 32'h0000_0000;
      pc_ID    <= '0;
      valid_ID <= 1'b0;
    end else begin
      pc_IF    <= pc_next;
      instr_ID <= instr_next;
      pc_ID    <= pc_id_next;
      valid_ID <= valid_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a cycle-level reference model checked every
// negedge, plus hand-computed literal expectations at key points.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, PCSrc, imem_we;
  logic [63:0] PCBranch;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [63:0] pc_IF, pc_ID;
  logic [31:0] instr_ID;
  logic        valid_ID;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  fetch_stage #(.N(64), .IMEM_DEPTH(64), .AW(6)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .PCSrc(PCSrc),
    .PCBranch(PCBranch), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .pc_IF(pc_IF), .instr_ID(instr_ID),
    .pc_ID(pc_ID), .valid_ID(valid_ID)
  );

  always #5 clk = ~clk;

  // Reference model: architectural PC, IF/ID fields and memory image.
  logic [31:0] m_mem [64];
  logic [63:0] m_pc = 64'd0, m_pcid = 64'd0;
  logic [31:0] m_instr = 32'd0;
  logic        m_valid = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc <= 64'd0; m_instr <= 32'd0; m_pcid <= 64'd0; m_valid <= 1'b0;
    end else if (PCSrc) begin
      m_pc <= {PCBranch[63:2], 2'b00};
      m_instr <= 32'd0; m_pcid <= 64'd0; m_valid <= 1'b0;
    end else if (stall) begin
      if (flush) begin
        m_instr <= 32'd0; m_pcid <= 64'd0; m_valid <= 1'b0;
      end
    end else begin
      m_pc <= m_pc + 64'd4;
      if (flush) begin
        m_instr <= 32'd0; m_pcid <= 64'd0; m_valid <= 1'b0;
      end else begin
        m_instr <= m_mem[m_pc[7:2]]; m_pcid <= m_pc; m_valid <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (imem_we) m_mem[imem_waddr] <= imem_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model pc_IF", pc_IF, m_pc);
      chk("model instr_ID", {32'd0, instr_ID}, {32'd0, m_instr});
      chk("model pc_ID", pc_ID, m_pcid);
      chk("model valid_ID", {63'd0, valid_ID}, {63'd0, m_valid});
    end
  end

  function automatic logic [31:0] word_of(input int i);
    logic [7:0] b;
    b = 8'(i);
    case (i)
      0: word_of = 32'hF840_0020;
      1: word_of = 32'hF805_13AD;
      2: word_of = 32'hB400_01E0;
      default: word_of = {16'hC0DE, b, ~b};
    endcase
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic lit(input string tag, input logic [63:0] pc, input logic [31:0] ins,
                     input logic [63:0] pid, input logic v);
    chk({tag, " pc_IF"}, pc_IF, pc);
    chk({tag, " instr_ID"}, {32'd0, instr_ID}, {32'd0, ins});
    chk({tag, " pc_ID"}, pc_ID, pid);
    chk({tag, " valid_ID"}, {63'd0, valid_ID}, {63'd0, v});
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; PCSrc = 1'b0; imem_we = 1'b0;
    PCBranch = 64'd0; imem_waddr = 6'd0; imem_wdata = 32'd0;
    cyc();
    chk_en = 1'b1;
    // Preload while in reset
    for (int i = 0; i < 64; i++) begin
      imem_we = 1'b1; imem_waddr = 6'(i); imem_wdata = word_of(i);
      cyc();
    end
    imem_we = 1'b0;
    lit("reset", 64'h0, 32'h0, 64'h0, 1'b0);

    // Sequential fetch
    reset = 1'b1;
    cyc(); lit("seq0", 64'h4, 32'hF840_0020, 64'h0, 1'b1);
    cyc(); lit("seq1", 64'h8, 32'hF805_13AD, 64'h4, 1'b1);

    // Stall two cycles
    stall = 1'b1;
    cyc(); lit("stall0", 64'h8, 32'hF805_13AD, 64'h4, 1'b1);
    cyc(); lit("stall1", 64'h8, 32'hF805_13AD, 64'h4, 1'b1);
    stall = 1'b0;
    cyc(); lit("seq2", 64'hC, 32'hB400_01E0, 64'h8, 1'b1);

    // Redirect
    PCSrc = 1'b1; PCBranch = 64'h3C;
    cyc(); lit("br", 64'h3C, 32'h0, 64'h0, 1'b0);
    PCSrc = 1'b0;
    cyc(); lit("br_tgt", 64'h40, 32'hC0DE_0FF0, 64'h3C, 1'b1);
    PCSrc = 1'b1; PCBranch = 64'h3E;
    cyc(); lit("br_misal", 64'h3C, 32'h0, 64'h0, 1'b0);

    // Priority conflicts
    stall = 1'b1; PCBranch = 64'h20;
    cyc(); lit("br_stall", 64'h20, 32'h0, 64'h0, 1'b0);
    PCSrc = 1'b0; stall = 1'b0;
    cyc(); lit("adv", 64'h24, 32'hC0DE_08F7, 64'h20, 1'b1);
    stall = 1'b1; flush = 1'b1;
    cyc(); lit("stall_flush", 64'h24, 32'h0, 64'h0, 1'b0);
    stall = 1'b0;
    cyc(); lit("flush", 64'h28, 32'h0, 64'h0, 1'b0);
    flush = 1'b0;

    // Async reset mid-run at pc_IF=0x10 with a valid entry
    PCSrc = 1'b1; PCBranch = 64'hC;
    cyc();
    PCSrc = 1'b0;
    cyc(); lit("pre_rst", 64'h10, 32'hC0DE_03FC, 64'hC, 1'b1);
    #2 reset = 1'b0;
    #1 lit("async_rst", 64'h0, 32'h0, 64'h0, 1'b0);
    cyc();
    reset = 1'b1;
    cyc(); lit("post_rst", 64'h4, 32'hF840_0020, 64'h0, 1'b1);

    // PC wrap
    PCSrc = 1'b1; PCBranch = 64'hFFFF_FFFF_FFFF_FFFC;
    cyc(); lit("wrap_br", 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 64'h0, 1'b0);
    PCSrc = 1'b0;
    cyc(); lit("wrap", 64'h0, 32'hC0DE_3FC0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);

    // Write to the word being fetched: old word latched now, new word later
    imem_we = 1'b1; imem_waddr = 6'd0; imem_wdata = 32'h8B02_0020;
    cyc(); lit("wr_old", 64'h4, 32'hF840_0020, 64'h0, 1'b1);
    imem_we = 1'b0; PCSrc = 1'b1; PCBranch = 64'h0;
    cyc();
    PCSrc = 1'b0;
    cyc(); lit("wr_new", 64'h4, 32'h8B02_0020, 64'h0, 1'b1);

    // Write during stall, then aliased fetch (0x104 maps to word 1)
    stall = 1'b1; imem_we = 1'b1; imem_waddr = 6'd1; imem_wdata = 32'h1234_5678;
    cyc(); lit("wr_stall", 64'h4, 32'h8B02_0020, 64'h0, 1'b1);
    stall = 1'b0; imem_we = 1'b0; PCSrc = 1'b1; PCBranch = 64'h104;
    cyc();
    PCSrc = 1'b0;
    cyc(); lit("alias", 64'h108, 32'h1234_5678, 64'h104, 1'b1);
    cyc();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
